// File: rtl/run_sequencer.sv
// run_sequencer: host-side stage in front of the processor top level.
// One start pulse runs NUM_PROGS programs back-to-back over the req/done
// handshake. For each program it measures the cycle count and aborts the run
// when a program exceeds TIMEOUT cycles.
module run_sequencer #(
    parameter int unsigned NUM_PROGS  = 3,
    parameter int unsigned REQ_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned PW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_done,
    output logic             dut_req,
    output logic [PW-1:0]    prog_id,
    output logic             busy,
    output logic [CNT_W-1:0] cycles,
    output logic             cycles_valid,
    output logic             timeout,
    output logic             all_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [CNT_W-1:0] REQ_LAST  = CNT_W'(REQ_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [PW-1:0]    PROG_LAST = PW'(NUM_PROGS - 1);

    logic             rst_meta_q, rst_n_q;
    logic [2:0]       state_q, state_d;
    logic [PW-1:0]    prog_id_q, prog_id_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             cv_q, cv_d;
    logic             timeout_q, timeout_d;
    logic             dut_req_q, busy_q, all_done_q;

    // Reset synchronizer: assertion propagates asynchronously, release is clocked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    // Next-state logic for the run FSM, program counter and cycle counter.
    always_comb begin
        state_d   = state_q;
        prog_id_d = prog_id_q;
        count_d   = count_q;
        cycles_d  = cycles_q;
        cv_d      = 1'b0;
        timeout_d = timeout_q;
        count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_REQ;
                    prog_id_d = '0;
                    timeout_d = 1'b0;
                    count_d   = '0;
                end
            end
            S_REQ: begin
                count_d = count_inc;
                if (count_q == REQ_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                count_d = count_inc;
                if (dut_done) begin
                    cycles_d = count_q;
                    cv_d     = 1'b1;
                    state_d  = (prog_id_q == PROG_LAST) ? S_FINISH : S_GAP;
                end else if (count_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    cycles_d  = count_q;
                    cv_d      = 1'b1;
                    state_d   = S_FINISH;
                end
            end
            S_GAP: begin
                // A done left high from the previous program must fall first,
                // otherwise it would end the next program immediately.
                count_d = count_inc;
                if (!dut_done) begin
                    prog_id_d = prog_id_q + PW'(1);
                    count_d   = '0;
                    state_d   = S_REQ;
                end else if (count_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    cycles_d  = count_q;
                    cv_d      = 1'b1;
                    state_d   = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State registers; outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q    <= S_IDLE;
            prog_id_q  <= '0;
            count_q    <= '0;
            cycles_q   <= '0;
            cv_q       <= 1'b0;
            timeout_q  <= 1'b0;
            dut_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            all_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_id_q  <= prog_id_d;
            count_q    <= count_d;
            cycles_q   <= cycles_d;
            cv_q       <= cv_d;
            timeout_q  <= timeout_d;
            dut_req_q  <= (state_d == S_REQ);
            busy_q     <= (state_d != S_IDLE);
            all_done_q <= (state_d == S_FINISH);
        end
    end

    assign dut_req      = dut_req_q;
    assign prog_id      = prog_id_q;
    assign busy         = busy_q;
    assign cycles       = cycles_q;
    assign cycles_valid = cv_q;
    assign timeout      = timeout_q;
    assign all_done     = all_done_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed testbench for run_sequencer (3 programs, REQ_CYCLES=2, TIMEOUT=64).
module tb_run_sequencer;

    localparam int REQ_CYC = 2;

    logic        clk;
    logic        reset;
    logic        start;
    logic        dut_done;
    logic        dut_req;
    logic [1:0]  prog_id;
    logic        busy;
    logic [15:0] cycles;
    logic        cycles_valid;
    logic        timeout;
    logic        all_done;
    logic [22:0] outs;

    int n_cmp = 0;
    int n_err = 0;
    int ad_n  = 0;
    int cv_n  = 0;
    int rq_n  = 0;

    run_sequencer #(
        .NUM_PROGS (3),
        .REQ_CYCLES(2),
        .TIMEOUT   (64),
        .CNT_W     (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dut_done    (dut_done),
        .dut_req     (dut_req),
        .prog_id     (prog_id),
        .busy        (busy),
        .cycles      (cycles),
        .cycles_valid(cycles_valid),
        .timeout     (timeout),
        .all_done    (all_done)
    );

    assign outs = {dut_req, prog_id, busy, cycles, cycles_valid, timeout, all_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse/level tallies, sampled on the active edge (pre-update values).
    always @(posedge clk) begin
        if (all_done)     ad_n++;
        if (cycles_valid) cv_n++;
        if (dut_req)      rq_n++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Plays the processor for one program. done_at is the REQ-relative cycle in
    // which done is presented, which is also the expected cycles value.
    task automatic run_prog(input int exp_pid, input int done_at, input int hold,
                            input bit never, input bit exp_last, input int start_at);
        int t;
        int req_hi;
        t = 0;
        while (!dut_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("req_rise", dut_req, 1);
        check_eq("prog_id", prog_id, exp_pid);
        req_hi = 1;
        for (int k = 1; k <= done_at + hold; k++) begin
            @(negedge clk);
            if (dut_req) req_hi++;
            start = (k == start_at);
            if (k == done_at && !never) dut_done = 1'b1;
            if (k == done_at + 1) begin
                check_eq("cyc_valid", cycles_valid, 1);
                check_eq("cycles", cycles, done_at);
                check_eq("timeout", timeout, never);
                check_eq("all_done", all_done, exp_last);
            end
            if (k == done_at + hold) begin
                check_eq("gap_req_low", dut_req, 0);
                dut_done = 1'b0;
            end
        end
        start = 1'b0;
        check_eq("req_len", req_hi, REQ_CYC);
    endtask

    initial begin
        int ad0, cv0, rq0, nreq;
        reset    = 1'b0;
        start    = 1'b0;
        dut_done = 1'b0;

        // T1: held in reset with toggling inputs, then idle after release.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start    = i[0];
            dut_done = i[1];
            check_eq("t1_rst_outs", outs, 0);
        end
        @(negedge clk);
        start    = 1'b0;
        dut_done = 1'b0;
        reset    = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("t1_idle_outs", outs, 0);

        // T2: three normal programs, done 20 cycles after req rises.
        ad0 = ad_n; cv0 = cv_n;
        do_start();
        run_prog(0, 20, 1, 0, 0, -1);
        run_prog(1, 20, 1, 0, 0, -1);
        run_prog(2, 20, 1, 0, 1, -1);
        repeat (3) @(negedge clk);
        check_eq("t2_busy_end", busy, 0);
        check_eq("t2_all_done_n", ad_n - ad0, 1);
        check_eq("t2_cv_n", cv_n - cv0, 3);
        check_eq("t2_timeout", timeout, 0);
        check_eq("t2_prog_id_hold", prog_id, 2);

        // T3: done held across GAP for 5 cycles on program 0.
        do_start();
        run_prog(0, 20, 5, 0, 0, -1);
        run_prog(1, 20, 1, 0, 0, -1);
        run_prog(2, 20, 1, 0, 1, -1);
        repeat (3) @(negedge clk);

        // T4: program 1 hangs; timeout at count 63, program 2 never requested.
        ad0 = ad_n;
        do_start();
        run_prog(0, 20, 1, 0, 0, -1);
        run_prog(1, 63, 1, 1, 1, -1);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dut_req) nreq++;
        end
        check_eq("t4_no_prog2", nreq, 0);
        check_eq("t4_busy", busy, 0);
        check_eq("t4_sticky", timeout, 1);
        check_eq("t4_all_done_n", ad_n - ad0, 1);
        do_start();
        check_eq("t4_to_clear", timeout, 0);
        run_prog(0, 20, 1, 0, 0, -1);
        run_prog(1, 20, 1, 0, 0, -1);
        run_prog(2, 20, 1, 0, 1, -1);
        repeat (3) @(negedge clk);

        // T5: start pulsed during RUN and during FINISH is ignored.
        ad0 = ad_n; cv0 = cv_n; rq0 = rq_n;
        do_start();
        run_prog(0, 20, 1, 0, 0, 10);
        run_prog(1, 20, 1, 0, 0, -1);
        run_prog(2, 20, 2, 0, 1, 21);
        repeat (10) @(negedge clk);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_all_done_n", ad_n - ad0, 1);
        check_eq("t5_cv_n", cv_n - cv0, 3);
        check_eq("t5_req_cycles", rq_n - rq0, 6);

        // T6: reset asserted during REQ drops req at once, no completion pulse.
        ad0 = ad_n;
        do_start();
        check_eq("t6_req_before", dut_req, 1);
        reset = 1'b0;
        #1;
        check_eq("t6_req_drop", dut_req, 0);
        check_eq("t6_outs", outs, 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("t6_idle_outs", outs, 0);
        check_eq("t6_all_done_n", ad_n - ad0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
